vliw_pc_sequencer: RTL and testbench

//  Next-generation program-counter unit for the multi-core VLIW CPU; replaces the pc register and pcjumper mux chain.

---
 rtl/vliw_pkg.sv | 18 +
 rtl/lane_priority_select.sv | 33 +++
 rtl/vliw_pc_sequencer.sv | 110 +++++++++++
 tb/tb_vliw_pc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared types and helpers for the VLIW program-counter sequencer.
package vliw_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_t;

  localparam int DEFAULT_PC_W         = 32;
  localparam int DEFAULT_BUNDLE_BYTES = 4;

  // Width of a lane index; a single-lane build still carries a 1-bit index.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_priority_select.sv
// Fixed-priority redirect arbiter: lowest lane index with a redirect wins.
module lane_priority_select
  import vliw_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PC_W  = DEFAULT_PC_W
) (
  input  logic [LANES-1:0]             redirect,
  input  logic [LANES*PC_W-1:0]        targets,
  output logic                         any,
  output logic                         multi,
  output logic [lane_idx_w(LANES)-1:0] winner,
  output logic [PC_W-1:0]              target
);

  localparam int IDX_W = lane_idx_w(LANES);

  always_comb begin
    winner = '0;
    target = '0;
    // Scan high to low so the lowest set lane is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (redirect[i]) begin
        winner = IDX_W'(i);
        target = targets[i*PC_W +: PC_W];
      end
    end
  end

  assign any   = |redirect;
  assign multi = ($countones(redirect) > 1);

endmodule

// File: rtl/vliw_pc_sequencer.sv
// Shared bundle PC for the multi-core VLIW CPU: redirect arbitration, stall hold,
// fetch handshake, halt, alignment and conflict flags, retired-bundle counter.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_RUN    | fetching; advances when stall=0 and fetch_ready=1
//  ST_HOLD   | downstream stalled; pc frozen, lane requests ignored
//  ST_HALTED | halt retired; pc frozen until reset
module vliw_pc_sequencer
  import vliw_pkg::*;
#(
  parameter int              LANES        = 4,
  parameter int              PC_W         = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              BUNDLE_BYTES = DEFAULT_BUNDLE_BYTES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             lane_redirect,
  input  logic [LANES*PC_W-1:0]        lane_target,
  input  logic                         halt_req,
  input  logic                         stall,
  input  logic                         fetch_ready,
  output logic [PC_W-1:0]              pc,
  output logic [PC_W-1:0]              pc_plus_step,
  output logic                         fetch_valid,
  output logic                         redirect_taken,
  output logic [lane_idx_w(LANES)-1:0] redirect_lane,
  output logic                         multi_redirect,
  output logic                         align_err,
  output logic                         halted,
  output logic [31:0]                  bundle_count
);

  localparam int              IDX_W      = lane_idx_w(LANES);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(BUNDLE_BYTES - 1);

  seq_state_t state, state_nxt;

  logic             sel_any;
  logic             sel_multi;
  logic [IDX_W-1:0] sel_lane;
  logic [PC_W-1:0]  sel_target;
  logic [PC_W-1:0]  aligned_target;
  logic             misaligned;
  logic             advance;

  lane_priority_select #(
    .LANES (LANES),
    .PC_W  (PC_W)
  ) u_select (
    .redirect (lane_redirect),
    .targets  (lane_target),
    .any      (sel_any),
    .multi    (sel_multi),
    .winner   (sel_lane),
    .target   (sel_target)
  );

  assign aligned_target = sel_target & ~ALIGN_MASK;
  assign misaligned     = |(sel_target & ALIGN_MASK);
  assign pc_plus_step   = pc + PC_W'(BUNDLE_BYTES);
  assign fetch_valid    = (state == ST_RUN) & ~stall;
  assign advance        = fetch_valid & fetch_ready;
  assign halted         = (state == ST_HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (stall)                   state_nxt = ST_HOLD;
        else if (advance && halt_req) state_nxt = ST_HALTED;
      end
      ST_HOLD:   if (!stall) state_nxt = ST_RUN;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RUN;
      pc             <= RESET_PC;
      redirect_taken <= 1'b0;
      redirect_lane  <= '0;
      multi_redirect <= 1'b0;
      align_err      <= 1'b0;
      bundle_count   <= '0;
    end else begin
      state          <= state_nxt;
      redirect_taken <= 1'b0;
      if (advance) begin
        if (bundle_count != 32'hFFFF_FFFF) bundle_count <= bundle_count + 32'd1;
        // A halting bundle keeps its own address so the halt point stays visible.
        if (halt_req) begin
          pc <= pc;
        end else if (sel_any) begin
          pc             <= aligned_target;
          redirect_taken <= 1'b1;
          redirect_lane  <= sel_lane;
          if (sel_multi)  multi_redirect <= 1'b1;
          if (misaligned) align_err      <= 1'b1;
        end else begin
          pc <= pc_plus_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_vliw_pc_sequencer.sv
// Directed-vector bench for vliw_pc_sequencer: a 32-bit PC instance and an 8-bit PC instance.
module tb_vliw_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]   lane_redirect;
  logic [127:0] lane_target;
  logic         halt_req, stall, fetch_ready;
  logic [31:0]  pc, pc_plus_step, bundle_count;
  logic         fetch_valid, redirect_taken, multi_redirect, align_err, halted;
  logic [1:0]   redirect_lane;

  logic [3:0]  lane_redirect8;
  logic [31:0] lane_target8;
  logic        halt_req8, stall8, fetch_ready8;
  logic [7:0]  pc8, pc_plus_step8;
  logic [31:0] bundle_count8;
  logic        fetch_valid8, redirect_taken8, multi_redirect8, align_err8, halted8;
  logic [1:0]  redirect_lane8;

  int n_checks = 0;
  int n_errors = 0;

  vliw_pc_sequencer #(.LANES(4), .PC_W(32), .RESET_PC(32'h0), .BUNDLE_BYTES(4)) dut (
    .clk(clk), .reset(reset), .lane_redirect(lane_redirect), .lane_target(lane_target),
    .halt_req(halt_req), .stall(stall), .fetch_ready(fetch_ready), .pc(pc),
    .pc_plus_step(pc_plus_step), .fetch_valid(fetch_valid), .redirect_taken(redirect_taken),
    .redirect_lane(redirect_lane), .multi_redirect(multi_redirect), .align_err(align_err),
    .halted(halted), .bundle_count(bundle_count)
  );

  vliw_pc_sequencer #(.LANES(4), .PC_W(8), .RESET_PC(8'h0), .BUNDLE_BYTES(4)) dut8 (
    .clk(clk), .reset(reset), .lane_redirect(lane_redirect8), .lane_target(lane_target8),
    .halt_req(halt_req8), .stall(stall8), .fetch_ready(fetch_ready8), .pc(pc8),
    .pc_plus_step(pc_plus_step8), .fetch_valid(fetch_valid8), .redirect_taken(redirect_taken8),
    .redirect_lane(redirect_lane8), .multi_redirect(multi_redirect8), .align_err(align_err8),
    .halted(halted8), .bundle_count(bundle_count8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; lane_redirect = '0; lane_target = '0; halt_req = 1'b0;
    stall = 1'b0; fetch_ready = 1'b1;
    lane_redirect8 = '0; lane_target8 = '0; halt_req8 = 1'b0; stall8 = 1'b0; fetch_ready8 = 1'b0;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_count", bundle_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_multi", multi_redirect, 0);
    chk("rst_fv", fetch_valid, 1);
    reset = 1'b0;

    // Sequential advance
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc, 64'(4 * i));
      chk("seq_fv", fetch_valid, 1);
      step();
    end
    chk("seq_count", bundle_count, 4);
    chk("seq_pc_end", pc, 16);
    chk("seq_plus", pc_plus_step, 20);

    // fetch_ready low freezes pc and count
    fetch_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fr0_pc", pc, 16);
      chk("fr0_count", bundle_count, 4);
      chk("fr0_fv", fetch_valid, 1);
      chk("fr0_halted", halted, 0);
    end
    fetch_ready = 1'b1;

    // Redirect conflict: lanes 1 and 3
    lane_redirect = 4'b0001; lane_target[31:0] = 32'h40;
    step();
    chk("r0_pc", pc, 32'h40);
    chk("r0_taken", redirect_taken, 1);
    chk("r0_multi", multi_redirect, 0);
    lane_redirect = 4'b1010; lane_target[63:32] = 32'h100; lane_target[127:96] = 32'h200;
    step();
    chk("rm_pc", pc, 32'h100);
    chk("rm_lane", redirect_lane, 1);
    chk("rm_multi", multi_redirect, 1);
    chk("rm_taken", redirect_taken, 1);
    lane_redirect = '0;
    step();
    chk("rm2_pc", pc, 32'h104);
    chk("rm2_taken", redirect_taken, 0);
    chk("rm2_multi_sticky", multi_redirect, 1);
    chk("rm2_lane_hold", redirect_lane, 1);
    chk("rm2_count", bundle_count, 7);

    // Stall with a pending lane0 redirect
    lane_redirect = 4'b0001; lane_target[31:0] = 32'h10;
    step();
    chk("s0_pc", pc, 32'h10);
    stall = 1'b1; lane_target[31:0] = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_pc", pc, 32'h10);
      chk("st_fv", fetch_valid, 0);
    end
    stall = 1'b0;
    #1;
    chk("st_hold_fv", fetch_valid, 0);
    step();
    chk("st_run_pc", pc, 32'h10);
    chk("st_run_fv", fetch_valid, 1);
    chk("st_run_count", bundle_count, 8);
    step();
    chk("st_redir_pc", pc, 32'h80);
    chk("st_redir_lane", redirect_lane, 0);
    chk("st_redir_count", bundle_count, 9);

    // Halt beats a simultaneous redirect
    lane_target[31:0] = 32'h20;
    step();
    chk("h0_pc", pc, 32'h20);
    halt_req = 1'b1; lane_target[31:0] = 32'h300;
    step();
    chk("h_halted", halted, 1);
    chk("h_pc", pc, 32'h20);
    chk("h_taken", redirect_taken, 0);
    chk("h_count", bundle_count, 11);
    chk("h_fv", fetch_valid, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("h_hold_pc", pc, 32'h20);
    end
    chk("h_hold_count", bundle_count, 11);
    chk("h_still_halted", halted, 1);
    reset = 1'b1;
    step();
    chk("hr_pc", pc, 0);
    chk("hr_halted", halted, 0);
    chk("hr_multi", multi_redirect, 0);
    chk("hr_count", bundle_count, 0);
    reset = 1'b0; halt_req = 1'b0; lane_redirect = '0;

    // 8-bit PC: wrap and alignment
    fetch_ready8 = 1'b1; lane_redirect8 = 4'b0001; lane_target8[7:0] = 8'hFC;
    step();
    chk("w_pc", pc8, 8'hFC);
    chk("w_plus", pc_plus_step8, 8'h00);
    lane_redirect8 = '0;
    step();
    chk("w_wrap_pc", pc8, 8'h00);
    chk("w_align", align_err8, 0);
    chk("w_multi", multi_redirect8, 0);
    chk("w_taken", redirect_taken8, 0);
    lane_redirect8 = 4'b0100; lane_target8[23:16] = 8'h31;
    step();
    chk("a_pc", pc8, 8'h30);
    chk("a_align", align_err8, 1);
    chk("a_lane", redirect_lane8, 2);
    chk("a_multi", multi_redirect8, 0);
    lane_redirect8 = '0;
    step();
    chk("a_sticky", align_err8, 1);
    chk("a_seq_pc", pc8, 8'h34);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
